// File: rtl/xoodyak_text_drain_if.sv
// Narrow result stream from the text drain toward the host.
// The master drives words; the slave returns out_ready.
interface xoodyak_text_drain_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [3:0]        out_kind;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_kind,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_kind,
        output out_ready
    );
endinterface

// File: rtl/xoodyak_text_drain.sv
// Buffers 192-bit core results in a 2-entry FIFO and serializes each entry,
// most-significant word first, onto a valid/ready word stream.
module xoodyak_text_drain #(
    parameter int WORD_W = 32
) (
    input  logic                 eph1,
    input  logic                 reset,
    input  logic [191:0]         textout_r,
    input  logic                 textout_valid,
    input  logic [4:0]           opmode,
    xoodyak_text_drain_if.master out_if,
    output logic                 overflow,
    output logic                 busy
);
    localparam int NW_FULL = 192 / WORD_W;
    localparam int NW_TAG  = 128 / WORD_W;
    localparam int CW      = $clog2(NW_FULL);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [195:0]  mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic [CW-1:0] cnt;

    logic [3:0]    head_kind;
    logic [191:0]  head_text;
    logic          is_tag;
    logic [CW-1:0] last_idx;
    logic          at_last;
    logic          xfer;
    logic          pop;
    logic          push;
    logic          drop;
    logic          unused_opmode;

    assign unused_opmode = opmode[4];

    assign head_kind = mem[rd_ptr][195:192];
    assign head_text = mem[rd_ptr][191:0];
    assign is_tag    = (head_kind == 4'd6) || (head_kind == 4'd8);
    assign last_idx  = is_tag ? CW'(NW_TAG - 1) : CW'(NW_FULL - 1);
    assign at_last   = (cnt == last_idx);

    // A final-word pop frees its slot in the same cycle, so a capture then is never dropped.
    assign xfer      = (state == SEND) && out_if.out_ready;
    assign pop       = xfer && at_last;
    assign push      = textout_valid && ((count != 2'd2) || pop);
    assign drop      = textout_valid && (count == 2'd2) && !pop;
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            if (drop) overflow <= 1'b1;
            if (pop)       cnt <= '0;
            else if (xfer) cnt <= cnt + CW'(1);
        end
    end

    // Entry storage is never reset; every output is gated by state or count.
    always_ff @(posedge eph1) begin
        if (push) mem[wr_ptr] <= {opmode[3:0], textout_r};
    end

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Looking at the incoming strobe in IDLE gives word 0 one cycle after capture.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if ((count != 2'd0) || textout_valid) state_nxt = SEND;
            SEND: if (pop && (count_nxt == 2'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_if.out_valid = 1'b0;
        out_if.out_last  = 1'b0;
        out_if.out_data  = '0;
        out_if.out_kind  = 4'd0;
        if (state == SEND) begin
            out_if.out_valid = 1'b1;
            out_if.out_last  = at_last;
            out_if.out_data  = head_text[191 - int'(cnt) * WORD_W -: WORD_W];
            out_if.out_kind  = head_kind;
        end
    end

    assign busy = (count != 2'd0);
endmodule

// File: tb/tb_xoodyak_text_drain.sv
// Self-checking bench for xoodyak_text_drain: vector table, directed corner
// sequences and randomized traffic against a queue-based model.
module tb_xoodyak_text_drain;
    localparam int W = 32;

    logic         eph1 = 1'b0;
    logic         reset = 1'b1;
    logic [191:0] textout_r = '0;
    logic         textout_valid = 1'b0;
    logic [4:0]   opmode = '0;
    logic         overflow;
    logic         busy;

    xoodyak_text_drain_if #(.WORD_W(W)) bus ();

    xoodyak_text_drain #(.WORD_W(W)) dut (
        .eph1          (eph1),
        .reset         (reset),
        .textout_r     (textout_r),
        .textout_valid (textout_valid),
        .opmode        (opmode),
        .out_if        (bus),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 eph1 = ~eph1;

    typedef struct {
        logic [3:0]   kind;
        logic [191:0] text;
    } ent_t;

    typedef struct {
        logic [191:0] text;
        logic [4:0]   op;
        int           exp_n;
        logic [31:0]  exp_first;
        logic [31:0]  exp_last;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: entries waiting, words already sent from the head, sticky drop flag.
    ent_t mq[$];
    int   m_idx = 0;
    logic m_ovf = 1'b0;

    // Observed transfer statistics for the current directed/table run.
    int          n_xfer;
    int          last_pos;
    logic [31:0] first_data;
    logic [31:0] last_data;

    localparam logic [191:0] T1 = 192'h87a06d5561b0d87c20a12db5d34783258ff75fe5d87c0e30;
    localparam logic [191:0] T2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int entry_len(input logic [3:0] kind);
        return (kind == 4'd6 || kind == 4'd8) ? 4 : 6;
    endfunction

    function automatic logic [31:0] word_of(input logic [191:0] text, input int k);
        logic [191:0] s;
        s = text << (32 * k);
        return s[191:160];
    endfunction

    task automatic model_clear();
        mq.delete();
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    task automatic clear_stats();
        n_xfer = 0;
        last_pos = 0;
        first_data = '0;
        last_data = '0;
    endtask

    // Compare DUT outputs with the model, then advance the model by one cycle.
    task automatic model_step(input logic v, input logic [191:0] t, input logic [4:0] op, input logic rdy);
        logic exp_valid;
        int   len;
        exp_valid = (mq.size() != 0);
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(exp_valid));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (exp_valid) begin
            len = entry_len(mq[0].kind);
            check("out_data", 64'(bus.out_data), 64'(word_of(mq[0].text, m_idx)));
            check("out_last", 64'(bus.out_last), 64'(m_idx == len - 1));
            check("out_kind", 64'(bus.out_kind), 64'(mq[0].kind));
            if (rdy) begin
                if (n_xfer == 0) first_data = bus.out_data;
                last_data = bus.out_data;
                if (bus.out_last) last_pos = n_xfer + 1;
                n_xfer++;
                m_idx++;
                if (m_idx == len) begin
                    void'(mq.pop_front());
                    m_idx = 0;
                end
            end
        end
        if (v) begin
            if (mq.size() < 2) mq.push_back('{kind: op[3:0], text: t});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic cycle(input logic v, input logic [191:0] t, input logic [4:0] op, input logic rdy);
        textout_valid = v;
        textout_r     = t;
        opmode        = op;
        bus.out_ready = rdy;
        @(negedge eph1);
        model_step(v, t, op, rdy);
        @(posedge eph1);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 5'd0, rdy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".out_last"},  64'(bus.out_last),  64'd0);
        check({tag, ".out_data"},  64'(bus.out_data),  64'd0);
        check({tag, ".out_kind"},  64'(bus.out_kind),  64'd0);
        check({tag, ".overflow"},  64'(overflow),      64'd0);
        check({tag, ".busy"},      64'(busy),          64'd0);
    endtask

    // Entered just after a rising edge; reset rises mid-cycle and outputs are checked before any edge.
    task automatic async_reset(input string tag);
        textout_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero(tag);
        model_clear();
        @(posedge eph1);
        #1 reset = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{T1, 5'h04, 6, 32'h87a06d55, 32'hd87c0e30};
        tbl[1] = '{T1, 5'h06, 4, 32'h87a06d55, 32'hd3478325};
        tbl[2] = '{T1, 5'h08, 4, 32'h87a06d55, 32'hd3478325};
        tbl[3] = '{T2, 5'h0f, 6, 32'h00010203, 32'h14151617};
        tbl[4] = '{T2, 5'h16, 4, 32'h00010203, 32'h0c0d0e0f};
        tbl[5] = '{T2, 5'h17, 6, 32'h00010203, 32'h14151617};
        tbl[6] = '{T2, 5'h18, 4, 32'h00010203, 32'h0c0d0e0f};

        bus.out_ready = 1'b0;
        clear_stats();
        repeat (2) @(posedge eph1);
        #1;
        check_all_zero("reset_hold");
        reset = 1'b0;
        model_clear();
        idle(4, 1'b1);

        // Table: one entry each, ready held high.
        for (int r = 0; r < 7; r++) begin
            clear_stats();
            cycle(1'b1, tbl[r].text, tbl[r].op, 1'b1);
            idle(10, 1'b1);
            check("tbl_nwords", 64'(n_xfer), 64'(tbl[r].exp_n));
            check("tbl_first", 64'(first_data), 64'(tbl[r].exp_first));
            check("tbl_lastword", 64'(last_data), 64'(tbl[r].exp_last));
            check("tbl_lastpos", 64'(last_pos), 64'(tbl[r].exp_n));
        end

        // Backpressure: ready pattern 1,0,0,1 repeating.
        clear_stats();
        cycle(1'b1, T1, 5'h04, 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0, '0, 5'd0, (i % 4 == 0) || (i % 4 == 3));
        idle(4, 1'b1);
        check("bp_nwords", 64'(n_xfer), 64'd6);
        check("bp_lastword", 64'(last_data), 64'hd87c0e30);

        // Overflow: three back-to-back strobes while stalled.
        clear_stats();
        cycle(1'b1, T1, 5'h04, 1'b0);
        cycle(1'b1, T2, 5'h04, 1'b0);
        cycle(1'b1, T1, 5'h06, 1'b0);
        idle(3, 1'b0);
        check("ovf_set", 64'(overflow), 64'd1);
        idle(16, 1'b1);
        check("ovf_nwords", 64'(n_xfer), 64'd12);
        check("ovf_lastword", 64'(last_data), 64'h14151617);
        check("ovf_sticky", 64'(overflow), 64'd1);
        async_reset("ovf_clear");

        // Third strobe lands on the first entry's final-word transfer.
        clear_stats();
        cycle(1'b1, T1, 5'h04, 1'b0);
        cycle(1'b1, T2, 5'h04, 1'b0);
        idle(5, 1'b1);
        cycle(1'b1, T2, 5'h03, 1'b1);
        check("coinc_no_ovf", 64'(overflow), 64'd0);
        idle(16, 1'b1);
        check("coinc_nwords", 64'(n_xfer), 64'd18);
        check("coinc_no_ovf_end", 64'(overflow), 64'd0);

        // Reset after word 2 of a full entry with a second entry buffered.
        clear_stats();
        cycle(1'b1, T1, 5'h04, 1'b0);
        cycle(1'b1, T2, 5'h05, 1'b1);
        cycle(1'b0, '0, 5'd0, 1'b1);
        cycle(1'b0, '0, 5'd0, 1'b1);
        check("mid_words_before", 64'(n_xfer), 64'd3);
        async_reset("mid_reset");
        clear_stats();
        idle(10, 1'b1);
        check("mid_no_words", 64'(n_xfer), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [191:0] t;
            logic [4:0]   op;
            t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: op = 5'h06;
                1: op = 5'h08;
                default: op = 5'($urandom_range(0, 31));
            endcase
            cycle($urandom_range(0, 3) == 0, t, op, $urandom_range(0, 9) < 7);
        end
        idle(20, 1'b1);
        check("rand_drained", 64'(mq.size()), 64'd0);
        check("rand_idle_valid", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
